stack_bus_master: RTL and testbench
===================================

Name: stack_bus_master

Overview:
- Initiator side of the 5-entry stack bus: accepts push/pop/get/clear requests on a valid/ready interface and sequences them onto the stack's COMMAND/INDEX/IO_DATA/RESET pins.
- Tracks occupancy so that illegal operations never reach the bus.
- Owns the tri-state IO_DATA turnaround, captures read data and returns one response per request.
- Sits between the processing logic and the stack; it is the only agent driving the stack's command pins.

Parameters:
- DEPTH, 5, number of stack entries (occupancy range 0..DEPTH).
- DATA_W, 4, width of IO_DATA and request/response data.
- IDX_W, 3, width of STK_INDEX and req_index.

Ports:
- CLK  input  1  single clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  master can accept a request this cycle.
- req_op  input  2  00 clear, 01 push, 10 pop, 11 get.
- req_data  input  DATA_W  value to push.
- req_index  input  IDX_W  get depth; 0 = top of stack.
- rsp_valid  output  1  one-cycle response strobe; no backpressure.
- rsp_data  output  DATA_W  read value (pop/get) or echoed value (push); 0 for clear/error.
- rsp_err  output  1  request rejected; qualified by rsp_valid.
- depth  output  3  current occupancy, 0..DEPTH.
- STK_COMMAND  output  2  stack command: 00 nop, 01 push, 10 pop, 11 get.
- STK_INDEX  output  IDX_W  stack get index.
- STK_IO_DATA  inout  DATA_W  shared data bus.
- STK_RESET  output  1  active-high stack clear.

Behaviour:
- FSM states: IDLE, ISSUE, CLEAR, RESP. All registered outputs change only on CLK rising edges, except on reset.

IDLE:
- req_ready=1, STK_COMMAND=00, STK_IO_DATA=Z.
- A request is accepted on a rising edge with req_valid=1. Latch op, data and index.
- Legality check against depth at the accept edge:
  - push is illegal when depth==DEPTH.
  - pop is illegal when depth==0.
  - get is illegal when req_index>=depth.
- Illegal request: go to RESP with err=1 and data=0. The bus stays nop and depth is unchanged.
- Legal clear: go to CLEAR.
- Legal push/pop/get: go to ISSUE.

ISSUE (exactly one cycle):
- STK_COMMAND=latched op.
- STK_INDEX=latched index for get, 0 otherwise.
- Push: STK_IO_DATA driven with latched data for the whole cycle.
- Pop/get: STK_IO_DATA=Z (the stack drives it).
- At the closing edge:
  - pop/get: capture STK_IO_DATA into rsp_data.
  - push: depth+1 and rsp_data=pushed value.
  - pop: depth-1.
  - get: depth unchanged.
- Next state: RESP.

CLEAR (one cycle):
- STK_RESET=1 and STK_COMMAND=00.
- At the closing edge: depth=0, then go to RESP with err=0 and data=0.

RESP (one cycle):
- rsp_valid=1, req_ready=0.
- Next state: IDLE.

Timing and throughput:
- Latency from the accept edge to rsp_valid is 2 cycles for legal bus ops and clear, and 1 cycle for errors.
- Throughput is one request per 3 cycles (1 idle + 1 issue + 1 resp), or per 2 cycles for errors.

Bus turnaround:
- STK_IO_DATA is driven only in ISSUE with a push, and is Z in every other state, including reset.
- No cycle exists in which both master and stack drive the bus: the command returns to nop in the same edge that releases the bus.

Reset:
- RESET low forces IDLE asynchronously with these values: depth=0, rsp_valid=0, rsp_err=0, rsp_data=0, STK_COMMAND=00, STK_INDEX=0, STK_IO_DATA=Z.
- STK_RESET = (RESET==0) OR (state==CLEAR). It clears the stack together with the master.
- Reset during ISSUE aborts the operation: no response is produced and depth reads 0.
- req_ready=0 while RESET is low.

Depth arithmetic:
- Unsigned, with saturation guaranteed by the legality checks. No wrap is ever visible on depth.
- The stack's internal head wrap modulo 5 is transparent to the master.

Request interface:
- req_* are ignored outside IDLE.
- A request held valid across RESP is accepted on the first IDLE edge.

Test Plan:
- Reset: drive RESET low mid-cycle with req_valid=1 -> asynchronously depth=0, STK_COMMAND=00, STK_IO_DATA=Z, STK_RESET=1, req_ready=0. Release RESET -> STK_RESET=0, req_ready=1.
- LIFO: push 3, 7, 9 -> three rsp with err=0 echoing 3, 7, 9, depth=3, STK_COMMAND=01 in exactly one cycle per push. Then pop, pop -> rsp_data 9, then 7, depth=1.
- Get: push 1, 2, 4, 8; get index 0 -> 8; get index 3 -> 1; get index 4 -> rsp_err=1 after 1 cycle, STK_COMMAND stays 00, depth=4.
- Full/empty: 5 pushes then a 6th push of 0xA -> err=1, depth=5, no bus activity. Clear -> STK_RESET high for exactly one cycle, depth=0. Pop -> err=1.
- Bus contention: across a mixed push/get/pop sequence, the bench asserts that STK_IO_DATA is never driven by the master while STK_COMMAND is 10 or 11. The stack model flags any X on the bus.
- Reset during ISSUE of a push of 5 -> no rsp_valid and depth=0. A subsequent pop is rejected with err=1.

Source files
------------

// File: rtl/stack_bus_master_if.sv
//------------------------------------------------------------------------------
// stack_bus_master_if : request/response handshake between the processing logic
//                       and the stack bus master.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface stack_bus_master_if #(
  parameter int DATA_W  = 4,
  parameter int IDX_W   = 3,
  parameter int DEPTH_W = 3
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [DATA_W-1:0]  req_data;
  logic [IDX_W-1:0]   req_index;
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_err;
  logic [DEPTH_W-1:0] depth;

  // master: the requesting processing logic; slave: the stack bus master block
  modport master (
    output req_valid, req_op, req_data, req_index,
    input  req_ready, rsp_valid, rsp_data, rsp_err, depth
  );

  modport slave (
    input  req_valid, req_op, req_data, req_index,
    output req_ready, rsp_valid, rsp_data, rsp_err, depth
  );
endinterface

`default_nettype wire

// File: rtl/stack_bus_master.sv
//------------------------------------------------------------------------------
// stack_bus_master : sequences push/pop/get/clear requests onto the stack pins,
//                    tracks occupancy and owns the IO_DATA turnaround.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stack_bus_master #(
  parameter int DEPTH  = 5,
  parameter int DATA_W = 4,
  parameter int IDX_W  = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  stack_bus_master_if.slave    req_if,
  output logic [1:0]           STK_COMMAND,
  output logic [IDX_W-1:0]     STK_INDEX,
  inout  wire  [DATA_W-1:0]    STK_IO_DATA,
  output logic                 STK_RESET
);

  localparam int DEPTH_W = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_GET   = 2'b11;
  localparam logic [1:0] CMD_NOP  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CLEAR = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [1:0]         cmd_q, cmd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               drive_q, drive_d;
  logic               illegal;

  always_comb begin
    illegal = 1'b0;
    case (req_if.req_op)
      OP_PUSH: illegal = (depth_q == DEPTH_W'(DEPTH));
      OP_POP:  illegal = (depth_q == '0);
      OP_GET:  illegal = (32'(req_if.req_index) >= 32'(depth_q));
      default: illegal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    depth_d    = depth_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    drive_d    = drive_q;

    case (state_q)
      S_IDLE: begin
        if (req_if.req_valid) begin
          op_d   = req_if.req_op;
          data_d = req_if.req_data;
          if (illegal) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = S_RESP;
          end else if (req_if.req_op == OP_CLEAR) begin
            state_d = S_CLEAR;
          end else begin
            cmd_d   = req_if.req_op;
            idx_d   = (req_if.req_op == OP_GET) ? req_if.req_index : '0;
            drive_d = (req_if.req_op == OP_PUSH);
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // Command and bus drive drop on the same edge, so the stack never
        // sees a nop cycle with the master still on IO_DATA.
        cmd_d     = CMD_NOP;
        idx_d     = '0;
        drive_d   = 1'b0;
        rsp_err_d = 1'b0;
        case (op_q)
          OP_PUSH: begin
            depth_d    = depth_q + DEPTH_W'(1);
            rsp_data_d = data_q;
          end
          OP_POP: begin
            depth_d    = depth_q - DEPTH_W'(1);
            rsp_data_d = STK_IO_DATA;
          end
          default: rsp_data_d = STK_IO_DATA;
        endcase
        state_d = S_RESP;
      end

      S_CLEAR: begin
        depth_d    = '0;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      op_q       <= OP_CLEAR;
      data_q     <= '0;
      depth_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cmd_q      <= CMD_NOP;
      idx_q      <= '0;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      depth_q    <= depth_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      drive_q    <= drive_d;
    end
  end

  assign req_if.req_ready = (state_q == S_IDLE) && RESET;
  assign req_if.rsp_valid = (state_q == S_RESP);
  assign req_if.rsp_data  = rsp_data_q;
  assign req_if.rsp_err   = rsp_err_q;
  assign req_if.depth     = depth_q;

  assign STK_COMMAND = cmd_q;
  assign STK_INDEX   = idx_q;
  assign STK_RESET   = !RESET || (state_q == S_CLEAR);
  assign STK_IO_DATA = drive_q ? data_q : {DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_stack_bus_master.sv
//------------------------------------------------------------------------------
// tb_stack_bus_master : directed bench with a 5-entry stack model on the bus.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_stack_bus_master;

  localparam int DEPTH  = 5;
  localparam int DATA_W = 4;
  localparam int IDX_W  = 3;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_GET   = 2'b11;

  logic              clk;
  logic              rst_n;
  logic [1:0]        stk_cmd;
  logic [IDX_W-1:0]  stk_idx;
  wire  [DATA_W-1:0] stk_bus;
  logic              stk_rst;

  int n_tests = 0;
  int n_fail  = 0;

  stack_bus_master_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH_W(3)) rif ();

  stack_bus_master #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .req_if      (rif),
    .STK_COMMAND (stk_cmd),
    .STK_INDEX   (stk_idx),
    .STK_IO_DATA (stk_bus),
    .STK_RESET   (stk_rst)
  );

  // Undriven bus reads all ones, which makes a released bus observable.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pull
    pullup (stk_bus[gi]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Stack model
  logic [DATA_W-1:0] stk_mem [DEPTH];
  int                stk_cnt;
  logic              stk_drv;
  logic [DATA_W-1:0] stk_val;

  always_comb begin
    stk_drv = 1'b0;
    stk_val = '0;
    if ((stk_cmd == OP_POP || stk_cmd == OP_GET) && int'(stk_idx) < stk_cnt) begin
      stk_drv = 1'b1;
      stk_val = stk_mem[stk_cnt - 1 - int'(stk_idx)];
    end
  end

  assign stk_bus = stk_drv ? stk_val : {DATA_W{1'bz}};

  always @(posedge clk or posedge stk_rst) begin
    if (stk_rst) begin
      stk_cnt <= 0;
    end else if (stk_cmd == OP_PUSH) begin
      if ($isunknown(stk_bus)) check_eq("stk_bus_x", 32'd1, 32'd0);
      if (stk_cnt < DEPTH) begin
        stk_mem[stk_cnt] <= stk_bus;
        stk_cnt          <= stk_cnt + 1;
      end
    end else if (stk_cmd == OP_POP && stk_cnt > 0) begin
      stk_cnt <= stk_cnt - 1;
    end
  end

  // Bus ownership monitor: stack owns the bus for pop/get, nobody for nop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stk_cmd == OP_POP || stk_cmd == OP_GET)
        check_eq("bus_stack_owned", 32'(stk_bus), 32'(stk_val));
      else if (stk_cmd == 2'b00)
        check_eq("bus_released", 32'(stk_bus), 32'hF);
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [3:0] d, input logic [2:0] idx,
                        input logic exp_err, input logic [3:0] exp_data, input logic [2:0] exp_depth);
    int  lat;
    int  cmd_cyc;
    int  rst_cyc;
    bit  got;
    @(negedge clk);
    check_eq("req_ready", 32'(rif.req_ready), 32'd1);
    rif.req_valid = 1'b1;
    rif.req_op    = op;
    rif.req_data  = d;
    rif.req_index = idx;
    @(posedge clk);
    #1;
    rif.req_valid = 1'b0;
    lat = 0; cmd_cyc = 0; rst_cyc = 0; got = 1'b0;
    for (int c = 1; c <= 4 && !got; c++) begin
      @(negedge clk);
      if (stk_cmd != 2'b00) cmd_cyc++;
      if (stk_rst) rst_cyc++;
      if (rif.rsp_valid) begin
        got = 1'b1;
        lat = c;
        check_eq("rsp_err", 32'(rif.rsp_err), 32'(exp_err));
        check_eq("rsp_data", 32'(rif.rsp_data), 32'(exp_data));
        check_eq("depth", 32'(rif.depth), 32'(exp_depth));
      end
    end
    check_eq("latency", 32'(lat), exp_err ? 32'd1 : 32'd2);
    check_eq("cmd_cycles", 32'(cmd_cyc), (op != OP_CLEAR && !exp_err) ? 32'd1 : 32'd0);
    check_eq("clr_cycles", 32'(rst_cyc), (op == OP_CLEAR && !exp_err) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int rsp_seen;
    rst_n         = 1'b0;
    rif.req_valid = 1'b1;
    rif.req_op    = OP_PUSH;
    rif.req_data  = 4'h1;
    rif.req_index = '0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_depth", 32'(rif.depth), 32'd0);
    check_eq("rst_cmd", 32'(stk_cmd), 32'd0);
    check_eq("rst_idx", 32'(stk_idx), 32'd0);
    check_eq("rst_bus", 32'(stk_bus), 32'hF);
    check_eq("rst_stk_reset", 32'(stk_rst), 32'd1);
    check_eq("rst_ready", 32'(rif.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rif.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rif.rsp_data), 32'd0);
    rif.req_valid = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    check_eq("rel_stk_reset", 32'(stk_rst), 32'd0);
    check_eq("rel_ready", 32'(rif.req_ready), 32'd1);

    // LIFO ordering
    do_req(OP_PUSH, 4'h3, 3'd0, 1'b0, 4'h3, 3'd1);
    do_req(OP_PUSH, 4'h7, 3'd0, 1'b0, 4'h7, 3'd2);
    do_req(OP_PUSH, 4'h9, 3'd0, 1'b0, 4'h9, 3'd3);
    do_req(OP_POP,  4'h0, 3'd0, 1'b0, 4'h9, 3'd2);
    do_req(OP_POP,  4'h0, 3'd0, 1'b0, 4'h7, 3'd1);

    // Asynchronous reset mid-cycle with a request pending
    @(negedge clk);
    #2;
    rif.req_valid = 1'b1;
    rif.req_op    = OP_PUSH;
    rst_n         = 1'b0;
    #1;
    check_eq("async_depth", 32'(rif.depth), 32'd0);
    check_eq("async_cmd", 32'(stk_cmd), 32'd0);
    check_eq("async_stk_reset", 32'(stk_rst), 32'd1);
    check_eq("async_ready", 32'(rif.req_ready), 32'd0);
    @(posedge clk);
    #3;
    rif.req_valid = 1'b0;
    rst_n         = 1'b1;
    #1;
    check_eq("async_rel_stk_reset", 32'(stk_rst), 32'd0);
    check_eq("async_rel_ready", 32'(rif.req_ready), 32'd1);

    // Get at various depths
    do_req(OP_PUSH, 4'h1, 3'd0, 1'b0, 4'h1, 3'd1);
    do_req(OP_PUSH, 4'h2, 3'd0, 1'b0, 4'h2, 3'd2);
    do_req(OP_PUSH, 4'h4, 3'd0, 1'b0, 4'h4, 3'd3);
    do_req(OP_PUSH, 4'h8, 3'd0, 1'b0, 4'h8, 3'd4);
    do_req(OP_GET,  4'h0, 3'd0, 1'b0, 4'h8, 3'd4);
    do_req(OP_GET,  4'h0, 3'd3, 1'b0, 4'h1, 3'd4);
    do_req(OP_GET,  4'h0, 3'd4, 1'b1, 4'h0, 3'd4);

    // Full, clear, empty
    do_req(OP_PUSH,  4'h6, 3'd0, 1'b0, 4'h6, 3'd5);
    do_req(OP_PUSH,  4'hA, 3'd0, 1'b1, 4'h0, 3'd5);
    do_req(OP_CLEAR, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0);
    do_req(OP_POP,   4'h0, 3'd0, 1'b1, 4'h0, 3'd0);

    // Mixed sequence under the bus ownership monitor
    do_req(OP_PUSH, 4'hC, 3'd0, 1'b0, 4'hC, 3'd1);
    do_req(OP_PUSH, 4'h3, 3'd0, 1'b0, 4'h3, 3'd2);
    do_req(OP_GET,  4'h0, 3'd1, 1'b0, 4'hC, 3'd2);
    do_req(OP_POP,  4'h0, 3'd0, 1'b0, 4'h3, 3'd1);
    do_req(OP_GET,  4'h0, 3'd0, 1'b0, 4'hC, 3'd1);
    do_req(OP_POP,  4'h0, 3'd0, 1'b0, 4'hC, 3'd0);

    // Reset while a push is on the bus
    @(negedge clk);
    rif.req_valid = 1'b1;
    rif.req_op    = OP_PUSH;
    rif.req_data  = 4'h5;
    @(posedge clk);
    #1;
    rif.req_valid = 1'b0;
    check_eq("issue_cmd", 32'(stk_cmd), 32'(OP_PUSH));
    check_eq("issue_bus", 32'(stk_bus), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_depth", 32'(rif.depth), 32'd0);
    check_eq("abort_cmd", 32'(stk_cmd), 32'd0);
    check_eq("abort_bus", 32'(stk_bus), 32'hF);
    @(posedge clk);
    #3 rst_n = 1'b1;
    rsp_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rif.rsp_valid) rsp_seen++;
    end
    check_eq("abort_no_rsp", 32'(rsp_seen), 32'd0);
    check_eq("abort_depth_after", 32'(rif.depth), 32'd0);
    do_req(OP_POP, 4'h0, 3'd0, 1'b1, 4'h0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
